// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 8N1 UART receiver with 16x oversampling, 3-sample
// majority vote per bit, false-start rejection, framing-error detection and
// a valid/ack output handshake with overrun pulse.
// Optional even-parity checking is built in when UART_RX_PARITY_EN is defined;
// without it the frame is plain 8N1 and parity_err is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for rxs low (start edge)
// START   | qualifying the start bit; majority 1 at sc=9 is a false start
// DATA    | shifting in 8 data bits LSB first, each decided at sc=9
// PARITY  | (UART_RX_PARITY_EN only) even parity bit over the data byte
// STOP    | stop bit decided at sc=9; leaves immediately to catch next start
// BREAK   | stop bit was low; wait for the line to return high

module uart_rx_oversample #(
    parameter int CLK_HZ     = 100000000,
    parameter int BIT_RATE   = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       rx_ack,
    output logic [7:0] parallel_out,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int DIV   = CLK_HZ / (BIT_RATE * OVERSAMPLE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, rxs_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         sc_q, sc_d;
    logic [2:0]         bit_q, bit_d;
    logic [1:0]         smp_q, smp_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               ovr_q, ovr_d;
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
    logic               perr_q, perr_d;
`endif

    logic tick;
    logic decide;
    logic wrap;
    logic maj;
    logic load;

    // Oversample tick and bit-timing strobes; the counter only runs in a frame.
    assign tick   = (state_q != S_IDLE) && (cnt_q == CNT_W'(DIV - 1));
    assign decide = tick && (sc_q == 4'd9);
    assign wrap   = tick && (sc_q == 4'd15);
    // Third sample is the live rxs value on the sc=9 tick.
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs_q) | (smp_q[1] & rxs_q);

    // Next-state, sampling, shifting and output-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        sc_d    = tick ? sc_q + 4'd1 : sc_q;
        bit_d   = bit_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        load    = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif

        if (tick && (sc_q == 4'd7)) smp_d[0] = rxs_q;
        if (tick && (sc_q == 4'd8)) smp_d[1] = rxs_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                sc_d  = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (decide && maj) begin
                    state_d = S_IDLE;
                end else if (wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (decide) shift_d = {maj, shift_q[7:1]};
                if (wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (decide) par_bad_d = (^shift_q) ^ maj;
                if (wrap) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (decide) begin
                    if (maj) begin
                        load    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        data_d  = load ? shift_q : data_q;
        valid_d = load ? 1'b1 : (rx_ack ? 1'b0 : valid_q);
        ovr_d   = load & valid_q & ~rx_ack;
`ifdef UART_RX_PARITY_EN
        perr_d  = load & par_bad_q;
`endif
    end

    // State and datapath registers with synchronous reset; line synchroniser resets high.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sc_q    <= '0;
            bit_q   <= '0;
            smp_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            sync1_q <= serial_in;
            rxs_q   <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sc_q    <= sc_d;
            bit_q   <= bit_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign parallel_out = data_q;
    assign rx_valid     = valid_q;
    assign rx_busy      = (state_q != S_IDLE);
    assign frame_err    = ferr_q;
    assign overrun      = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Self-checking bench for uart_rx_oversample. The receiver is run with a
// clock of exactly 64 clocks per bit (DIV = 4) so the whole run stays short.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_oversample;

    localparam int BIT_RATE = 115200;
    localparam int OVS      = 16;
    localparam int DIV      = 4;
    localparam int CLK_HZ   = BIT_RATE * OVS * DIV;
    localparam int BIT_CLK  = DIV * OVS;
    // Start edge driven just after posedge k0: 2 synchroniser edges, IDLE->START
    // on k3, then the stop decision lands on the tick that ends the decision
    // sc=9 of the stop bit; rx_valid is registered on that edge.
`ifdef UART_RX_PARITY_EN
    localparam int LAT      = 3 + DIV * 170;
`else
    localparam int LAT      = 3 + DIV * 154;
`endif
    // 3 us at the bench clock, well under half a bit.
    localparam int GLITCH   = 22;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_in;
    logic       rx_ack;
    logic [7:0] parallel_out;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
`ifdef UART_RX_PARITY_EN
    logic       par_flip;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int ferr_tot = 0;
    int ovr_tot  = 0;
    int perr_tot = 0;
    int perr_wv  = 0;

    uart_rx_oversample #(
        .CLK_HZ    (CLK_HZ),
        .BIT_RATE  (BIT_RATE),
        .OVERSAMPLE(OVS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_in   (serial_in),
        .rx_ack      (rx_ack),
        .parallel_out(parallel_out),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    // Pulse outputs are totalled as high cycles, so a stretched pulse shows up.
    always @(negedge clk) begin
        ferr_tot <= ferr_tot + int'(frame_err);
        ovr_tot  <= ovr_tot + int'(overrun);
        perr_tot <= perr_tot + int'(parity_err);
        perr_wv  <= perr_wv + int'(parity_err & rx_valid);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    // Called just after a posedge; returns just after a posedge with the line idle.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop);
        serial_in = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n, gap, got, f0, o0, p0, w0, bsy;
        logic [7:0] rec[2];

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'hA5, 1};
        vecs[2] = '{8'h55, 1'b1, 1'b1, 8'h55, 0};
        vecs[3] = '{8'h96, 1'b1, 1'b1, 8'h96, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};

        serial_in = 1'b1;
        rx_ack    = 1'b0;
        reset     = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_flip  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_parallel_out", int'(parallel_out), 0);
        check("reset_rx_valid", int'(rx_valid), 0);
        check("reset_rx_busy", int'(rx_busy), 0);
        check("reset_pulses", ferr_tot + ovr_tot + perr_tot, 0);

        // First byte: latency from start edge and rx_busy held across the frame.
        f0 = ferr_tot; o0 = ovr_tot;
        n = 0; gap = 0; got = 0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (n < LAT + BIT_CLK && got == 0) begin
                    @(posedge clk);
                    n++;
                    @(negedge clk);
                    if (rx_valid) got = 1;
                    else if (n >= 3 && !rx_busy) gap++;
                end
            end
        join
        check("a5_valid_seen", got, 1);
        check("a5_latency_window", int'(n >= LAT - DIV && n <= LAT + DIV), 1);
        check("a5_busy_gap", gap, 0);
        wait_bits(1);
        check("a5_data", int'(parallel_out), 8'hA5);
        check("a5_no_errors", (ferr_tot - f0) + (ovr_tot - o0), 0);
        ack_pulse();
        check("a5_valid_cleared", int'(rx_valid), 0);

        // Ack with nothing pending is a no-op.
        ack_pulse();
        check("idle_ack_valid", int'(rx_valid), 0);
        check("idle_ack_data", int'(parallel_out), 8'hA5);

        for (int v = 0; v < 6; v++) begin
            f0 = ferr_tot; o0 = ovr_tot;
            send_frame(vecs[v].data, vecs[v].stop);
            wait_bits(1);
            check($sformatf("vec%0d_valid", v), int'(rx_valid), int'(vecs[v].exp_valid));
            check($sformatf("vec%0d_data", v), int'(parallel_out), int'(vecs[v].exp_data));
            check($sformatf("vec%0d_frame_err", v), ferr_tot - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_overrun", v), ovr_tot - o0, 0);
            check($sformatf("vec%0d_busy_after", v), int'(rx_busy), 0);
            if (vecs[v].exp_valid) begin
                ack_pulse();
                check($sformatf("vec%0d_valid_cleared", v), int'(rx_valid), 0);
            end
        end

        // Back-to-back frames with no idle gap, each acked as soon as seen.
        f0 = ferr_tot; o0 = ovr_tot; got = 0;
        rec[0] = 8'hEE; rec[1] = 8'hEE;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    n = 0;
                    @(negedge clk);
                    while (!rx_valid && n < 12 * BIT_CLK) begin
                        @(negedge clk);
                        n++;
                    end
                    if (rx_valid) begin
                        got++;
                        rec[k] = parallel_out;
                        @(posedge clk);
                        #1;
                        ack_pulse();
                    end
                end
            end
        join
        wait_bits(1);
        check("b2b_count", got, 2);
        check("b2b_first", int'(rec[0]), 8'h00);
        check("b2b_second", int'(rec[1]), 8'hFF);
        check("b2b_errors", (ferr_tot - f0) + (ovr_tot - o0), 0);

        // Short low glitch on an idle line is a false start.
        f0 = ferr_tot; bsy = 0;
        fork
            begin
                serial_in = 1'b0;
                repeat (GLITCH) @(posedge clk);
                #1;
                serial_in = 1'b1;
            end
            begin
                repeat (3 * BIT_CLK) begin
                    @(negedge clk);
                    if (rx_busy) bsy = 1;
                end
            end
        join
        check("glitch_busy_seen", bsy, 1);
        check("glitch_busy_after", int'(rx_busy), 0);
        check("glitch_valid", int'(rx_valid), 0);
        check("glitch_frame_err", ferr_tot - f0, 0);

        // Overrun: second byte lands while the first is still unacknowledged.
        o0 = ovr_tot;
        send_frame(8'h11, 1'b1);
        wait_bits(1);
        check("ovr_hold_valid", int'(rx_valid), 1);
        check("ovr_first_data", int'(parallel_out), 8'h11);
        send_frame(8'h22, 1'b1);
        wait_bits(1);
        check("ovr_pulse", ovr_tot - o0, 1);
        check("ovr_data", int'(parallel_out), 8'h22);
        check("ovr_valid", int'(rx_valid), 1);
        ack_pulse();

        // Ack in the very cycle the next byte completes: no overrun.
        send_frame(8'h33, 1'b1);
        wait_bits(1);
        o0 = ovr_tot;
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1;
                ack_pulse();
            end
        join
        wait_bits(1);
        check("coinc_overrun", ovr_tot - o0, 0);
        check("coinc_valid", int'(rx_valid), 1);
        check("coinc_data", int'(parallel_out), 8'h44);
        ack_pulse();
        check("coinc_valid_cleared", int'(rx_valid), 0);

        // Reset in the middle of data bit 4 with a byte pending.
        send_frame(8'h5A, 1'b1);
        wait_bits(1);
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (5 * BIT_CLK + BIT_CLK / 2) @(posedge clk);
                #1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                check("rst_mid_valid", int'(rx_valid), 0);
                check("rst_mid_data", int'(parallel_out), 0);
                check("rst_mid_busy", int'(rx_busy), 0);
                check("rst_mid_pulses", int'(frame_err) + int'(overrun) + int'(parity_err), 0);
                reset = 1'b0;
            end
        join
        // The rest of the aborted frame may decode as a stray byte; drain it.
        wait_bits(12);
        if (rx_valid) ack_pulse();
        f0 = ferr_tot; o0 = ovr_tot;
        send_frame(8'h96, 1'b1);
        wait_bits(1);
        check("post_rst_valid", int'(rx_valid), 1);
        check("post_rst_data", int'(parallel_out), 8'h96);
        check("post_rst_errors", (ferr_tot - f0) + (ovr_tot - o0), 0);
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so even parity needs a 1; send 0 instead.
        p0 = perr_tot; w0 = perr_wv;
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        par_flip = 1'b0;
        wait_bits(1);
        check("par_bad_pulse", perr_tot - p0, 1);
        check("par_bad_with_valid", perr_wv - w0, 1);
        check("par_bad_valid", int'(rx_valid), 1);
        check("par_bad_data", int'(parallel_out), 8'h07);
        ack_pulse();
        p0 = perr_tot;
        send_frame(8'h07, 1'b1);
        wait_bits(1);
        check("par_good_pulse", perr_tot - p0, 0);
        check("par_good_data", int'(parallel_out), 8'h07);
        ack_pulse();
`else
        p0 = perr_tot; w0 = perr_wv;
        check("parity_err_tied", (perr_tot - p0) + (perr_wv - w0) + int'(parity_err), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
- UART receive stage on the serial side of the existing transmitter. Consumes the transmitter's `serial_out` and delivers bytes to `parallel_out`, closing the loopback.
- Frame format: 8N1, LSB first, idle-high line.
- Uses 16x oversampling with 3-sample majority vote, false-start rejection, framing-error detection and a valid/ack output handshake with overrun flag.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz
- BIT_RATE, 115200, line bit rate in bits/s
- OVERSAMPLE, 16, sample ticks per bit (fixed 16; other values unsupported)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- serial_in  input  1  asynchronous UART line, idle high
- rx_ack  input  1  consumer acknowledge; clears rx_valid
- parallel_out  output  8  last received byte
- rx_valid  output  1  byte available; held until acknowledged
- rx_busy  output  1  high while a frame is in progress (state != IDLE)
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: new byte landed while rx_valid still high
- parity_err  output  1  one-cycle pulse (see Optional Feature)

Behaviour:
- Reset: one clock; reset is synchronous and active-high (`clk`, `reset`). All outputs 0, `parallel_out` = 0x00, state IDLE, counters 0, synchroniser flops = 1. Reset mid-frame aborts the frame; no pulse is emitted.
- Synchroniser: 2 flip-flops on `serial_in`; all logic uses the second flop (`rxs`).
- Tick generator:
  - DIV = CLK_HZ/(BIT_RATE*OVERSAMPLE), integer division (54 at defaults).
  - Counter runs 0..DIV-1; tick is asserted for one clock when counter = DIV-1.
  - Counter is forced to 0 on IDLE->START.
- Sample counter `sc` runs 0..15 per bit and advances on each tick. Samples are captured at sc = 7, 8, 9; the bit value is the majority of 3, decided at sc = 9.
- States:
  - IDLE: on `rxs` = 0, go to START; clear `sc` and tick counter.
  - START: decide at sc = 9. Majority 1 = false start: return to IDLE, no output. Majority 0: continue; enter DATA when sc wraps 15->0.
  - DATA: 8 bits shifted in LSB first, each decided at sc = 9. After bit 7 wraps, go to STOP (or PARITY if enabled).
  - STOP: decided at sc = 9, then move immediately to next state so the following start edge is caught.
    - Majority 1: load `parallel_out`, set rx_valid, go to IDLE.
    - Majority 0: byte discarded, frame_err pulses, go to BREAK.
  - BREAK: wait for `rxs` = 1, then IDLE.
- Latency: rx_valid rises 154 ticks (+/-1 tick) after IDLE detects `rxs` low. At defaults this is about 8316 clk, plus 2 synchroniser cycles.
- Handshake:
  - rx_valid stays 1 until a cycle with rx_ack = 1; it is 0 on the following cycle.
  - rx_ack with rx_valid = 0 is ignored.
  - New byte completes in the same cycle as rx_ack: new data is loaded, rx_valid stays 1, no overrun.
  - New byte completes with rx_valid = 1 and rx_ack = 0: `parallel_out` is overwritten, rx_valid stays 1, overrun pulses one cycle.
- `parallel_out` is stable at all times except the load cycle.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP; even parity is expected over the 8 data bits, majority-sampled like any other bit.
  - On mismatch, the byte is still delivered after a valid stop bit, and parity_err pulses one cycle in the same cycle rx_valid rises.
  - Frame is 11 bits; latency becomes 170 ticks.
- Undefined: no PARITY state, parity_err tied 0, 8N1 framing only.

Test Plan:
- Reset, idle line high, send 0xA5 at 115200 -> parallel_out = 0xA5, rx_valid = 1 about 8316 clk after start edge; frame_err = overrun = 0; rx_busy high throughout the frame.
- Back-to-back 0x00 then 0xFF with zero idle gap, rx_ack pulsed after each -> two rx_valid assertions, data 0x00 then 0xFF, no errors.
- 3 us low glitch (< half bit) on idle line -> rx_busy pulses, returns to IDLE; rx_valid, frame_err stay 0.
- Send 0x3C with stop bit forced 0, then line high -> frame_err one-cycle pulse, rx_valid 0, parallel_out unchanged; next 0x55 received normally.
- Send 0x11, no ack, then 0x22 -> overrun pulse when 0x22 lands, parallel_out = 0x22, rx_valid 1. Repeat with rx_ack coincident with completion -> no overrun.
- Assert reset at data bit 4 of 0x96 -> all outputs 0 next cycle; a subsequent full 0x96 frame is received correctly. With UART_RX_PARITY_EN: send 0x07 with parity bit 0 -> rx_valid with parity_err pulse.
